// File: rtl/display_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package display_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } scan_state_t;

    // One-hot digit select for a digit index (widest legal display).
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_prescaler.sv
// Slot prescaler: counts CLK_DIV cycles per digit slot, flags the slot end
// and whether the next cycle lies inside the anti-ghosting blank window.
module scan_prescaler #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_slot_end,
    output logic o_blank_next
);

    localparam int unsigned     CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Next count: wrap at slot end, held at zero while scanning is disabled.
    always_comb begin
        w_cnt_next = '0;
        o_slot_end = 1'b0;
        if (i_en) begin
            if (r_cnt == LAST) begin
                o_slot_end = 1'b1;
            end else begin
                w_cnt_next = r_cnt + CW'(1);
            end
        end
        o_blank_next = (32'(w_cnt_next) < BLANK_CYCLES);
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Double-buffered value (shadow -> active at frame boundary), registered
// nibble / one-hot digit enables, blank window at the start of each slot.
// Optional leading-zero blanking: define DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    output logic                          pending,
    output logic [DIGIT_W-1:0]            nibble,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_tick
);

    localparam int unsigned   IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    scan_state_t                   r_state;
    scan_state_t                   w_state_next;
    logic [IW-1:0]                 r_idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_shadow;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_active;
    logic                          r_pending;
    logic [DIGIT_W-1:0]            r_nibble;
    logic [NUM_DIGITS-1:0]         r_digit_en;
    logic                          r_frame_tick;

    logic                          w_slot_end;
    logic                          w_blank_next;
    logic                          w_frame_end;
    logic                          w_show;
    logic [MAX_DIGITS-1:0]         w_sel8;
    logic [NUM_DIGITS-1:0]         w_digit_en_next;
    logic [DIGIT_W-1:0]            w_cur_digit;

    scan_prescaler #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .o_slot_end   (w_slot_end),
        .o_blank_next (w_blank_next)
    );

    assign w_frame_end = w_slot_end && (r_idx == LAST_IDX);
    assign w_cur_digit = r_active[DIGIT_W*int'(r_idx) +: DIGIT_W];
    assign w_sel8      = onehot(3'(r_idx));

`ifdef DISPLAY_SCAN_LZB_EN
    logic [IW-1:0] w_top;

    // Position of the most significant nonzero digit (0 when value is 0).
    always_comb begin
        w_top = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            if (r_active[DIGIT_W*k +: DIGIT_W] != '0) begin
                w_top = IW'(k);
            end
        end
    end

    assign w_show = (r_idx <= w_top);
`else
    assign w_show = 1'b1;
`endif

    // Next scan state and next digit enables (from the current state).
    always_comb begin
        w_state_next    = S_BLANK;
        w_digit_en_next = '0;
        case (r_state)
            S_BLANK: begin
                if (en && !w_blank_next) begin
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_state_next = (en && !w_blank_next) ? S_DRIVE : S_BLANK;
                if (en && w_show) begin
                    w_digit_en_next = w_sel8[NUM_DIGITS-1:0];
                end
            end
            default: begin
                w_state_next = S_BLANK;
            end
        endcase
    end

    // Scan state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Digit index, double buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_nibble     <= '0;
            r_digit_en   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_nibble   <= w_cur_digit;
            r_digit_en <= w_digit_en_next;
            if (en) begin
                r_frame_tick <= w_frame_end;
                if (w_slot_end) begin
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
                end
                // Active always takes the pre-load shadow, so a load on the
                // boundary cycle is held over to the following frame.
                if (w_frame_end && r_pending) begin
                    r_active <= r_shadow;
                end
            end else begin
                r_frame_tick <= 1'b0;
                r_idx        <= '0;
                r_active     <= r_shadow;
            end

            if (load) begin
                r_shadow  <= data_in;
                r_pending <= 1'b1;
            end else if (!en || w_frame_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pending    = r_pending;
    assign nibble     = r_nibble;
    assign digit_en   = r_digit_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed vector table, reset / enable corner
// sequences, and randomized traffic against a frame-level reference model.
module tb_display_scan_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CD = 8;
    localparam int unsigned B  = 2;
`ifdef DISPLAY_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   data_in = '0;
    logic          pending;
    logic [3:0]    nibble;
    logic [3:0]    digit_en;
    logic          frame_tick;

    int unsigned   errors = 0;
    int unsigned   checks = 0;

    // Reference model state: position within frame as a plain cycle count.
    int unsigned   m_t;
    logic [15:0]   m_active, m_shadow;
    logic          m_pending;
    logic [3:0]    e_nib, e_den;
    logic          e_ft;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] data;
        int unsigned n;
        logic [3:0]  nib;
        logic [3:0]  den;
        logic        ft;
        logic        pend;
    } vec_t;

    vec_t tbl [20];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS   (N),
        .CLK_DIV      (CD),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .pending    (pending),
        .nibble     (nibble),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dig(input logic [15:0] v, input int unsigned k);
        logic [15:0] s;
        s = v >> (4 * k);
        return s[3:0];
    endfunction

    // A digit is lit unless blanking is on and every digit at or above it is zero.
    function automatic bit shown(input logic [15:0] v, input int unsigned k);
        if (!LZB) return 1'b1;
        return (k == 0) || ((v >> (4 * k)) != 16'h0);
    endfunction

    task automatic model_reset();
        m_t       = 0;
        m_active  = '0;
        m_shadow  = '0;
        m_pending = 1'b0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input logic e, input logic l, input logic [15:0] d);
        int unsigned cnt, idx;
        bit          bnd;
        cnt   = m_t % CD;
        idx   = m_t / CD;
        bnd   = e && (cnt == CD - 1) && (idx == N - 1);
        e_nib = dig(m_active, idx);
        e_den = (e && cnt >= B && shown(m_active, idx)) ? 4'(1 << idx) : 4'h0;
        e_ft  = bnd;
        if (e) begin
            if (bnd && m_pending) m_active = m_shadow;
            m_t = (m_t + 1) % (N * CD);
        end else begin
            m_active = m_shadow;
            m_t      = 0;
        end
        if (l) begin
            m_shadow  = d;
            m_pending = 1'b1;
        end else if (!e || bnd) begin
            m_pending = 1'b0;
        end
    endtask

    task automatic step(input logic e, input logic l, input logic [15:0] d);
        @(negedge clk);
        en      = e;
        load    = l;
        data_in = d;
        model_step(e, l, d);
        @(posedge clk);
        #1;
        chk("nibble", 32'(nibble), 32'(e_nib));
        chk("digit_en", 32'(digit_en), 32'(e_den));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        chk("pending", 32'(pending), 32'(m_pending));
    endtask

    initial begin
        logic [3:0] acc;
        logic       e, l;

        // en, load, data, cycles, nibble, digit_en, frame_tick, pending
        tbl[0]  = '{1'b1, 1'b1, 16'h1234,  1, 4'h0, 4'b0000, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 31, 4'h0, (LZB ? 4'b0000 : 4'b1000), 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000,  1, 4'h4, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000,  2, 4'h4, 4'b0001, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000,  6, 4'h3, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000,  2, 4'h3, 4'b0010, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'hABCD,  1, 4'h3, 4'b0010, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 20, 4'h1, 4'b1000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000,  3, 4'hD, 4'b0001, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 16'h1111,  1, 4'hD, 4'b0001, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 27, 4'hA, 4'b1000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 16'h2222,  1, 4'hA, 4'b1000, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h0000,  3, 4'h1, 4'b0001, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 29, 4'h1, 4'b1000, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 16'h0000,  3, 4'h2, 4'b0001, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 16'h0000, 16, 4'h2, 4'b0100, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 16'h0000,  1, 4'h2, 4'b0000, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000,  3, 4'h2, 4'b0000, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 16'h0000,  2, 4'h2, 4'b0000, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 16'h0000,  1, 4'h2, 4'b0001, 1'b0, 1'b0};

        // Power-on reset.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nibble", 32'(nibble), 32'h0);
        chk("rst_digit_en", 32'(digit_en), 32'h0);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        rst = 1'b0;

        // Directed vector table.
        for (int r = 0; r < 20; r++) begin
            for (int unsigned c = 0; c < tbl[r].n; c++) begin
                step(tbl[r].en, (c == 0) ? tbl[r].ld : 1'b0, tbl[r].data);
            end
            chk($sformatf("row%0d_nibble", r), 32'(nibble), 32'(tbl[r].nib));
            chk($sformatf("row%0d_digit_en", r), 32'(digit_en), 32'(tbl[r].den));
            chk($sformatf("row%0d_frame_tick", r), 32'(frame_tick), 32'(tbl[r].ft));
            chk($sformatf("row%0d_pending", r), 32'(pending), 32'(tbl[r].pend));
        end

        // Asynchronous reset mid-DRIVE with a load outstanding.
        step(1'b1, 1'b1, 16'h5678);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_nibble", 32'(nibble), 32'h0);
        chk("async_rst_digit_en", 32'(digit_en), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_frame_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // After reset the discarded load must not reach the display.
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 16'h0);
            acc |= nibble;
        end
        chk("post_rst_dark_nibble", 32'(acc), 32'h0);
        chk("post_rst_pending", 32'(pending), 32'h0);

        // Digits lit across one frame for 0x0050 and 0x0000.
        step(1'b0, 1'b1, 16'h0050);
        step(1'b0, 1'b0, 16'h0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 16'h0);
            acc |= digit_en;
        end
        chk("lit_0050", 32'(acc), LZB ? 32'h3 : 32'hF);
        step(1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 16'h0);
            acc |= digit_en;
        end
        chk("lit_0000", 32'(acc), LZB ? 32'h1 : 32'hF);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 15) != 0);
            l = ($urandom_range(0, 7) == 0);
            step(e, l, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-segment 7-segment display.
- Sequences one shared 4-bit-to-7-segment decoder across NUM_DIGITS digit positions.
- Each cycle it presents the current digit's nibble to the decoder and drives one-hot digit enables.
- Holds a double-buffered display value so a host load never tears a frame.
- Sits between the host logic and the segment decoder / digit driver pins.

Parameters:
NUM_DIGITS, 4, digit positions scanned (legal 1..8)
CLK_DIV, 50000, clk cycles per digit slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 500, cycles at slot start with all digits off (anti-ghosting; 0 = no blanking)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable; 0 = display dark, scan held at slot 0
load  in  1  single-cycle pulse: capture data_in into shadow buffer
data_in  in  4*NUM_DIGITS  digit k = data_in[4k+3:4k]; digit 0 rightmost
pending  out  1  shadow holds a value not yet shown
nibble  out  4  code to decoder; nibble[3] drives decoder MSB input i1, nibble[0] drives i4
digit_en  out  NUM_DIGITS  one-hot active-high digit select
frame_tick  out  1  one-cycle pulse at end of each full scan frame

Behaviour:
- Reset (async, rst=1) values: cnt=0, idx=0, shadow=0, active=0, pending=0, nibble=0, digit_en=0, frame_tick=0.
- State machine per slot: BLANK for cnt in 0..BLANK_CYCLES-1, then DRIVE for cnt in BLANK_CYCLES..CLK_DIV-1.
- Prescaler cnt has width $clog2(CLK_DIV). It counts 0..CLK_DIV-1. At CLK_DIV-1, cnt goes to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- All outputs are registered.
  - nibble = active digit idx, valid for the whole slot including BLANK, so the decoder settles before enable.
  - digit_en = 0 in BLANK; digit_en = (1<<idx) in DRIVE. Changes are seen one cycle after the state change.
- Load:
  - load=1 sets shadow<=data_in and pending<=1. Loads are accepted every cycle; the last one wins.
- Frame boundary (cnt=CLK_DIV-1 and idx=NUM_DIGITS-1):
  - frame_tick=1 for one cycle.
  - If pending, active<=shadow and pending<=0.
- Simultaneous load and frame boundary:
  - active takes the old shadow.
  - shadow takes the new data_in.
  - pending stays 1.
- en=0:
  - cnt=0, idx=0, state BLANK, digit_en=0, frame_tick=0.
  - active<=shadow every cycle, and pending is cleared unless load is asserted in that cycle.
  - Loads are still accepted.
- en rising: the scan starts with the BLANK of digit 0. The first DRIVE occurs BLANK_CYCLES cycles later, with digit_en visible one cycle after that.
- rst asserted mid-slot: all outputs go to reset values immediately. Any pending load is discarded.
- NUM_DIGITS=1: idx is always 0, and every slot end is a frame boundary.

Optional Feature:
DISPLAY_SCAN_LZB_EN (leading-zero blanking).
- Defined: during DRIVE, digit_en stays 0 for any digit k above the most significant nonzero digit of active. Digit 0 is always shown, so the value 0 shows a single "0". Suppressed slots keep their full timing, so the frame period does not change.
- Undefined: all digits are driven.

Decomposition:
- Package display_pkg:
  - localparam DIGIT_W=4
  - typedef enum logic {S_BLANK, S_DRIVE} scan_state_t
  - function onehot(idx) returning the digit-select vector
- Sub-module scan_prescaler (cnt, slot_end, blank flag) is natural and reusable.
- The leading-zero detector stays inline.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
- Reset then en=1 with load of 16'h1234 before the first frame end -> first frame dark (active=0, nibble=0). From frame 2: slot0 nibble=4, digit_en=0001 in cycles 3..8 of the slot; slots 1..3 give nibble 3,2,1 and digit_en 0010/0100/1000. frame_tick every 32 cycles.
- Load 16'hABCD mid-frame -> pending=1 until frame_tick. Digits unchanged until the next slot0, then D,C,B,A.
- Load on the exact frame-boundary cycle, with the prior shadow 16'h1111 and the new value 16'h2222 -> next frame shows 1111, pending=1, the following frame shows 2222.
- en dropped mid-slot2 -> digit_en=0 next cycle, cnt/idx=0. en re-raised -> BLANK of digit 0 lasts 2 cycles before digit_en=0001.
- rst pulsed mid-DRIVE -> digit_en, nibble and pending go to 0 asynchronously. After release, the display is dark until a load plus frame boundary.
- With DISPLAY_SCAN_LZB_EN, active=16'h0050 -> digit_en asserted only in slots 0 and 1. active=16'h0000 -> only slot 0 enabled.
